joy_db15_tx: RTL and testbench

Controller-side responder for the DB15 serial joystick protocol on the USER port. It latches two 16-bit player button words and shifts them out on `joy_data` in response to the host's `joy_load`/`joy_clk` strobes. It lets a core drive a second MiSTer's DB15 input, and serves as the bit-exact model the `joy_db15` receiver is verified against. It sits between the board-level USER_IN/USER_OUT pins and any source of 16-bit button words.

---
 rtl/joy_db15.sv | 143 ++++++++++++++
 tb/tb_joy_db15_tx.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/joy_db15.sv
// DB15 serial joystick responder: filters the host's joy_load/joy_clk strobes and
// shifts two latched 16-bit button words out on joy_data, active low, LSB first.
module joy_db15_tx #(
    parameter int FILT = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        joy_clk,
    input  logic        joy_load,
    input  logic [15:0] joystick1,
    input  logic [15:0] joystick2,
    output logic        joy_data,
    output logic        frame_done,
    output logic        overrun
);

    localparam logic [3:0] FILT_CNT = 4'(FILT);
    localparam logic [5:0] FULL     = 6'd32;

    logic        jclk_meta_q, jclk_meta_d;
    logic        jclk_sync_q, jclk_sync_d;
    logic        jclk_filt_q, jclk_filt_d;
    logic [3:0]  jclk_cnt_q,  jclk_cnt_d;
    logic        jclk_prev_q, jclk_prev_d;
    logic [3:0]  jclk_cnt_inc;

    logic        jload_meta_q, jload_meta_d;
    logic        jload_sync_q, jload_sync_d;
    logic        jload_filt_q, jload_filt_d;
    logic [3:0]  jload_cnt_q,  jload_cnt_d;
    logic [3:0]  jload_cnt_inc;

    logic [31:0] shreg_q,      shreg_d;
    logic [5:0]  bit_cnt_q,    bit_cnt_d;
    logic        overrun_q,    overrun_d;
    logic        frame_done_q, frame_done_d;
    logic        joy_data_q,   joy_data_d;

    logic        clk_rise;

    // Two-flop synchronizers; the host strobes share no clock with us.
    always_comb begin
        jclk_meta_d  = joy_clk;
        jclk_sync_d  = jclk_meta_q;
        jload_meta_d = joy_load;
        jload_sync_d = jload_meta_q;
    end

    // Glitch filters: a level must disagree with the filtered value for FILT
    // consecutive cycles before it is accepted.
    always_comb begin
        jclk_cnt_inc = jclk_cnt_q + 4'd1;
        jclk_filt_d  = jclk_filt_q;
        jclk_cnt_d   = 4'd0;
        if (jclk_sync_q != jclk_filt_q) begin
            if (jclk_cnt_inc == FILT_CNT) begin
                jclk_filt_d = jclk_sync_q;
            end else begin
                jclk_cnt_d = jclk_cnt_inc;
            end
        end
    end

    always_comb begin
        jload_cnt_inc = jload_cnt_q + 4'd1;
        jload_filt_d  = jload_filt_q;
        jload_cnt_d   = 4'd0;
        if (jload_sync_q != jload_filt_q) begin
            if (jload_cnt_inc == FILT_CNT) begin
                jload_filt_d = jload_sync_q;
            end else begin
                jload_cnt_d = jload_cnt_inc;
            end
        end
    end

    assign jclk_prev_d = jclk_filt_q;
    assign clk_rise    = jclk_filt_q & ~jclk_prev_q;

    // Load is level-sensitive and dominates any coincident shift clock.
    always_comb begin
        shreg_d      = shreg_q;
        bit_cnt_d    = bit_cnt_q;
        overrun_d    = overrun_q;
        frame_done_d = 1'b0;
        if (!jload_filt_q) begin
            shreg_d   = {joystick2, joystick1};
            bit_cnt_d = 6'd0;
            overrun_d = 1'b0;
        end else if (clk_rise) begin
            if (bit_cnt_q < FULL) begin
                shreg_d   = {1'b0, shreg_q[31:1]};
                bit_cnt_d = bit_cnt_q + 6'd1;
                if (bit_cnt_q == 6'd31) begin
                    frame_done_d = 1'b1;
                end
            end else begin
                overrun_d = 1'b1;
            end
        end
        // Output follows next state so the wire updates with the shift itself.
        joy_data_d = (bit_cnt_d == FULL) ? 1'b1 : ~shreg_d[0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            jclk_meta_q  <= 1'b0;
            jclk_sync_q  <= 1'b0;
            jclk_filt_q  <= 1'b0;
            jclk_cnt_q   <= 4'd0;
            jclk_prev_q  <= 1'b0;
            jload_meta_q <= 1'b1;
            jload_sync_q <= 1'b1;
            jload_filt_q <= 1'b1;
            jload_cnt_q  <= 4'd0;
            shreg_q      <= 32'd0;
            bit_cnt_q    <= FULL;
            overrun_q    <= 1'b0;
            frame_done_q <= 1'b0;
            joy_data_q   <= 1'b1;
        end else begin
            jclk_meta_q  <= jclk_meta_d;
            jclk_sync_q  <= jclk_sync_d;
            jclk_filt_q  <= jclk_filt_d;
            jclk_cnt_q   <= jclk_cnt_d;
            jclk_prev_q  <= jclk_prev_d;
            jload_meta_q <= jload_meta_d;
            jload_sync_q <= jload_sync_d;
            jload_filt_q <= jload_filt_d;
            jload_cnt_q  <= jload_cnt_d;
            shreg_q      <= shreg_d;
            bit_cnt_q    <= bit_cnt_d;
            overrun_q    <= overrun_d;
            frame_done_q <= frame_done_d;
            joy_data_q   <= joy_data_d;
        end
    end

    assign joy_data   = joy_data_q;
    assign frame_done = frame_done_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_joy_db15_tx.sv
// Bench for joy_db15_tx: drives host-side load/clock strobes and checks the
// serial stream, frame_done, overrun, glitch rejection and reset behaviour.
module tb_joy_db15_tx;

    logic        clk;
    logic        reset;
    logic        joy_clk;
    logic        joy_load;
    logic [15:0] joystick1;
    logic [15:0] joystick2;
    logic        joy_data;
    logic        frame_done;
    logic        overrun;

    typedef struct {
        logic [15:0] j1;
        logic [15:0] j2;
        logic [31:0] exp_word;
    } frame_vec_t;

    frame_vec_t  vecs [4];
    logic        exp_q [$];
    logic [31:0] rx_word;
    int          errors   = 0;
    int          checks   = 0;
    int          fd_count = 0;

    joy_db15_tx #(.FILT(3)) dut (
        .clk        (clk),
        .reset      (reset),
        .joy_clk    (joy_clk),
        .joy_load   (joy_load),
        .joystick1  (joystick1),
        .joystick2  (joystick2),
        .joy_data   (joy_data),
        .frame_done (frame_done),
        .overrun    (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (frame_done === 1'b1) fd_count++;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout, want finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got %h, want %h", name, act, req);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulseClk();
        joy_clk = 1'b1;
        waitCycles(10);
        joy_clk = 1'b0;
        waitCycles(10);
    endtask

    // Load a pair of words, release, then scramble the inputs to show they are not re-sampled.
    task automatic applyStimulus(input logic [15:0] j1, input logic [15:0] j2);
        joystick1 = j1;
        joystick2 = j2;
        joy_load  = 1'b0;
        waitCycles(20);
        joy_load  = 1'b1;
        waitCycles(10);
        joystick1 = ~j1;
        joystick2 = ~j2;
    endtask

    task automatic checkOutput(input string name, input int idx);
        logic e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s: got empty scoreboard, want entry", name);
        end else begin
            e = exp_q.pop_front();
            check(name, {31'd0, joy_data}, {31'd0, e});
        end
        rx_word[idx] = ~joy_data;
    endtask

    task automatic shiftOut(input string tag, input logic [31:0] exp_word, input int first);
        int fd0;
        fd0 = fd_count;
        for (int i = first; i < 32; i++) begin
            exp_q.push_back(~exp_word[i]);
            checkOutput($sformatf("%s bit%0d", tag, i), i);
            pulseClk();
        end
        check({tag, " word"}, rx_word, exp_word);
        check({tag, " frame_done"}, 32'(fd_count - fd0), 32'd1);
        check({tag, " idle"}, {31'd0, joy_data}, 32'd1);
        check({tag, " overrun"}, {31'd0, overrun}, 32'd0);
    endtask

    task automatic runFrame(input string tag, input frame_vec_t v);
        rx_word = '0;
        applyStimulus(v.j1, v.j2);
        shiftOut(tag, v.exp_word, 0);
    endtask

    initial begin
        logic [31:0] w;

        vecs[0] = '{16'h0015, 16'h8001, 32'h8001_0015};
        vecs[1] = '{16'hFFFF, 16'h0000, 32'h0000_FFFF};
        vecs[2] = '{16'hA5A5, 16'h5A5A, 32'h5A5A_A5A5};
        vecs[3] = '{16'h0000, 16'hFFFF, 32'hFFFF_0000};

        reset     = 1'b1;
        joy_clk   = 1'b0;
        joy_load  = 1'b1;
        joystick1 = 16'h0;
        joystick2 = 16'h0;
        waitCycles(3);
        reset = 1'b0;
        check("reset joy_data", {31'd0, joy_data}, 32'd1);
        check("reset bit_cnt", {26'd0, dut.bit_cnt_q}, 32'd32);
        check("reset shreg", dut.shreg_q, 32'd0);
        for (int i = 0; i < 100; i++) begin
            waitCycles(1);
            check("idle outputs", {29'd0, joy_data, frame_done, overrun}, 32'b100);
        end

        for (int v = 0; v < 4; v++) begin
            runFrame($sformatf("vec%0d", v), vecs[v]);
        end

        // Extra host clocks past the frame end.
        runFrame("ovr", vecs[0]);
        for (int i = 0; i < 3; i++) begin
            pulseClk();
            check("ovr extra data", {31'd0, joy_data}, 32'd1);
        end
        check("ovr flag", {31'd0, overrun}, 32'd1);
        check("ovr bit_cnt", {26'd0, dut.bit_cnt_q}, 32'd32);
        joy_load = 1'b0;
        waitCycles(10);
        check("ovr cleared", {31'd0, overrun}, 32'd0);
        joy_load = 1'b1;
        waitCycles(10);

        // Short spikes on both strobes must be invisible.
        w = vecs[2].exp_word;
        applyStimulus(vecs[2].j1, vecs[2].j2);
        for (int i = 0; i < 5; i++) pulseClk();
        check("spike pre bit_cnt", {26'd0, dut.bit_cnt_q}, 32'd5);
        joy_clk = 1'b1;
        waitCycles(2);
        joy_clk = 1'b0;
        waitCycles(12);
        check("spike clk bit_cnt", {26'd0, dut.bit_cnt_q}, 32'd5);
        check("spike clk shreg", dut.shreg_q, w >> 5);
        check("spike clk data", {31'd0, joy_data}, {31'd0, ~w[5]});
        joy_load = 1'b0;
        waitCycles(2);
        joy_load = 1'b1;
        waitCycles(12);
        check("spike load bit_cnt", {26'd0, dut.bit_cnt_q}, 32'd5);
        check("spike load shreg", dut.shreg_q, w >> 5);
        check("spike load data", {31'd0, joy_data}, {31'd0, ~w[5]});

        // Reset in the middle of a frame.
        w = vecs[0].exp_word;
        applyStimulus(vecs[0].j1, vecs[0].j2);
        for (int i = 0; i < 10; i++) pulseClk();
        check("mid bit_cnt", {26'd0, dut.bit_cnt_q}, 32'd10);
        check("mid data", {31'd0, joy_data}, {31'd0, ~w[10]});
        reset = 1'b1;
        waitCycles(1);
        reset = 1'b0;
        check("rst data", {31'd0, joy_data}, 32'd1);
        check("rst bit_cnt", {26'd0, dut.bit_cnt_q}, 32'd32);
        check("rst overrun", {31'd0, overrun}, 32'd0);
        waitCycles(5);
        runFrame("post rst", vecs[2]);

        // Load falling and clock rising together: load wins, exact latency.
        joystick1 = 16'h0001;
        joystick2 = 16'hFFFF;
        joy_load  = 1'b0;
        joy_clk   = 1'b1;
        waitCycles(5);
        check("simul early data", {31'd0, joy_data}, 32'd1);
        waitCycles(1);
        check("simul first data", {31'd0, joy_data}, 32'd0);
        check("simul bit_cnt", {26'd0, dut.bit_cnt_q}, 32'd0);
        waitCycles(14);
        joy_clk = 1'b0;
        waitCycles(10);
        joy_load = 1'b1;
        waitCycles(10);
        check("simul after release", {31'd0, joy_data}, 32'd0);
        check("simul bit_cnt rel", {26'd0, dut.bit_cnt_q}, 32'd0);
        rx_word = '0;
        shiftOut("simul", 32'hFFFF_0001, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
